encode_imm_arith: RTL and testbench
===================================

ENCODE_IMM_ARITH -- requirements
Module: encode_imm_arith

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-003 SHALL have port in_valid, input, 1 bit: request present.
REQ-004 SHALL have port in_ready, output, 1 bit: request can be accepted.
REQ-005 SHALL have port kind, input, imm_arith_kind_t: operation to encode.
REQ-006 SHALL have ports rd and rs1, input, 5 bits each: destination and source register indices.
REQ-007 SHALL have port imm, input, 12 bits: immediate; for shift kinds, imm[4:0] is shamt.
REQ-008 SHALL have port out_valid, output, 1 bit: encoded word present.
REQ-009 SHALL have port out_ready, input, 1 bit: consumer accepts the word.
REQ-010 SHALL have port instr, output, 32 bits: RV32I OP-IMM instruction word.
REQ-011 SHALL have port err, output, 1 bit: the word at head is invalid; qualified by out_valid.

Function
REQ-012 SHALL accept a request on an edge where in_valid && in_ready; SHALL transfer a word on an edge where out_valid && out_ready.
REQ-013 SHALL encode non-shift kinds as {imm[11:0], rs1, funct3, rd, 7'b0010011}; addi=000, slti=010, sltiu=011, xori=100, ori=110, andi=111.
REQ-014 SHALL encode shift kinds as {funct7, imm[4:0], rs1, funct3, rd, 7'b0010011}; slli=001/0000000, srli=101/0000000, srai=101/0100000.
REQ-015 SHALL, for kind iak_invalid or any unlisted value, store instr=32'h0 with err=1.
REQ-016 SHALL buffer words in a 2-entry FIFO with states EMPTY, ONE and FULL; head word drives instr and err.
REQ-017 SHALL have a latency of 1 cycle: a word accepted at edge N is visible with out_valid=1 after edge N when the FIFO was EMPTY.
REQ-018 SHALL drive in_ready=1 exactly when state!=FULL; in_ready SHALL be registered and have no combinational dependence on out_ready.
REQ-019 SHALL, on a simultaneous push and pop in state ONE, remain in ONE with the new word at head.
REQ-020 SHALL make these transitions: EMPTY->ONE on push; ONE->FULL on push without pop; ONE->EMPTY on pop without push; FULL->ONE on pop.
REQ-021 SHALL keep instr and err stable while out_valid=1 and out_ready=0.
REQ-022 SHALL preserve FIFO ordering; no word SHALL be dropped or duplicated.

Reset
REQ-023 SHALL, while rst=0, immediately force state=EMPTY, out_valid=0, in_ready=0, instr=32'h0 and err=0.
REQ-024 SHALL drive in_ready=1 starting from the first clk edge after rst deasserts.
REQ-025 SHALL discard buffered words when reset is asserted mid-operation; no word SHALL appear after reset.

Configuration
REQ-026 SHALL, when ENCODE_IMM_ARITH_SHAMT_CHECK_EN is defined, treat a shift kind with imm[11:5]!=0 as invalid: instr=32'h0, err=1.
REQ-027 SHALL, when ENCODE_IMM_ARITH_SHAMT_CHECK_EN is not defined, ignore imm[11:5] for shift kinds and encode them per REQ-014 with err=0.

Structure
REQ-028 SHALL take imm_arith_kind_t from package instr_type; constants OPCODE_OP_IMM, the OP-IMM funct3 values and FUNCT7_SRA SHALL be added to instr_type.
REQ-029 SHALL place word formatting in one combinational sub-module, imm_arith_pack (kind, rd, rs1, imm -> instr, err); the top SHALL hold the FIFO and handshake.

Verification
REQ-030 SHALL cover: reset release, then addi rd=1 rs1=0 imm=5 -> 0x00500093, err=0, one cycle later.
REQ-031 SHALL cover: srai rd=2 rs1=3 imm=7 -> 0x4071D113; andi rd=5 rs1=6 imm=12'hFFF -> 0xFFF37293.
REQ-032 SHALL cover: three back-to-back pushes with out_ready=0 -> in_ready=0 after the second; first word held stable; all three delivered in order once out_ready=1.
REQ-033 SHALL cover: kind=iak_invalid -> instr=0, err=1; slli imm=12'h021 -> 0x0 with err=1 if the macro is defined, else 0x00101013-pattern with shamt=1 and err=0 (rd=0, rs1=0: 0x00101013).
REQ-034 SHALL cover: rst asserted while FULL -> out_valid=0 at once; after release, no stale word is output.
REQ-035 SHALL cover: push and pop every cycle in ONE for 8 cycles -> continuous out_valid, 8 ordered words, state stays ONE.

Source files
------------

// File: rtl/instr_type_pkg.sv
// Shared types and RV32I OP-IMM encoding constants for the immediate-arithmetic
// encoder. Build option: ENCODE_IMM_ARITH_SHAMT_CHECK_EN (see imm_arith_pack).
package instr_type;

  typedef enum logic [3:0] {
    IAK_INVALID = 4'd0,
    IAK_ADDI    = 4'd1,
    IAK_SLTI    = 4'd2,
    IAK_SLTIU   = 4'd3,
    IAK_XORI    = 4'd4,
    IAK_ORI     = 4'd5,
    IAK_ANDI    = 4'd6,
    IAK_SLLI    = 4'd7,
    IAK_SRLI    = 4'd8,
    IAK_SRAI    = 4'd9
  } imm_arith_kind_t;

  localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;

  localparam logic [2:0] F3_ADDI  = 3'b000;
  localparam logic [2:0] F3_SLLI  = 3'b001;
  localparam logic [2:0] F3_SLTI  = 3'b010;
  localparam logic [2:0] F3_SLTIU = 3'b011;
  localparam logic [2:0] F3_XORI  = 3'b100;
  localparam logic [2:0] F3_SRXI  = 3'b101;
  localparam logic [2:0] F3_ORI   = 3'b110;
  localparam logic [2:0] F3_ANDI  = 3'b111;

  localparam logic [6:0] FUNCT7_ZERO = 7'b0000000;
  localparam logic [6:0] FUNCT7_SRA  = 7'b0100000;

  // One FIFO entry: encoded word plus its invalid flag.
  typedef struct packed {
    logic [31:0] instr;
    logic        err;
  } imm_arith_word_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } fifo_state_t;

endpackage

// File: rtl/encode_imm_arith_pack.sv
// Combinational OP-IMM word formatter.
// Build option: ENCODE_IMM_ARITH_SHAMT_CHECK_EN -- when defined, a shift with
// any of imm[11:5] set is rejected as invalid instead of silently truncated.
import instr_type::*;

module imm_arith_pack (
  input  imm_arith_kind_t kind,
  input  logic [4:0]      rd,
  input  logic [4:0]      rs1,
  input  logic [11:0]     imm,
  output logic [31:0]     instr,
  output logic            err
);

  logic       w_ok;
  logic       w_shift;
  logic [2:0] w_f3;
  logic [6:0] w_f7;

  // Decode the kind into funct3/funct7 and whether it is a shift form.
  always_comb begin
    w_ok    = 1'b1;
    w_shift = 1'b0;
    w_f3    = F3_ADDI;
    w_f7    = FUNCT7_ZERO;
    case (kind)
      IAK_ADDI:  w_f3 = F3_ADDI;
      IAK_SLTI:  w_f3 = F3_SLTI;
      IAK_SLTIU: w_f3 = F3_SLTIU;
      IAK_XORI:  w_f3 = F3_XORI;
      IAK_ORI:   w_f3 = F3_ORI;
      IAK_ANDI:  w_f3 = F3_ANDI;
      IAK_SLLI:  begin w_f3 = F3_SLLI; w_shift = 1'b1; end
      IAK_SRLI:  begin w_f3 = F3_SRXI; w_shift = 1'b1; end
      IAK_SRAI:  begin w_f3 = F3_SRXI; w_shift = 1'b1; w_f7 = FUNCT7_SRA; end
      default:   w_ok = 1'b0;
    endcase
`ifdef ENCODE_IMM_ARITH_SHAMT_CHECK_EN
    if (w_shift && (imm[11:5] != 7'd0)) w_ok = 1'b0;
`else
`endif
  end

  // Assemble the word; invalid requests produce an all-zero word.
  always_comb begin
    instr = 32'h0;
    err   = 1'b1;
    if (w_ok) begin
      err = 1'b0;
      if (w_shift) instr = {w_f7, imm[4:0], rs1, w_f3, rd, OPCODE_OP_IMM};
      else         instr = {imm, rs1, w_f3, rd, OPCODE_OP_IMM};
    end
  end

endmodule

// File: rtl/encode_imm_arith.sv
// OP-IMM encoder front end: formats requests and buffers them in a 2-entry
// FIFO with valid/ready handshakes on both sides. Build option:
// ENCODE_IMM_ARITH_SHAMT_CHECK_EN (forwarded to imm_arith_pack).
//
// state    | meaning
// ST_EMPTY | no word buffered, out_valid=0
// ST_ONE   | one word at head, can push and pop together
// ST_FULL  | head and tail occupied, in_ready=0
import instr_type::*;

module encode_imm_arith (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  imm_arith_kind_t kind,
  input  logic [4:0]      rd,
  input  logic [4:0]      rs1,
  input  logic [11:0]     imm,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     instr,
  output logic            err
);

  fifo_state_t     r_state;
  fifo_state_t     w_next_state;
  imm_arith_word_t r_head;
  imm_arith_word_t r_tail;
  imm_arith_word_t w_new;
  logic            r_in_ready;
  logic            w_push;
  logic            w_pop;

  imm_arith_pack u_pack (
    .kind  (kind),
    .rd    (rd),
    .rs1   (rs1),
    .imm   (imm),
    .instr (w_new.instr),
    .err   (w_new.err)
  );

  assign w_push    = in_valid && r_in_ready;
  assign w_pop     = (r_state != ST_EMPTY) && out_ready;
  assign in_ready  = r_in_ready;
  assign out_valid = (r_state != ST_EMPTY);
  assign instr     = r_head.instr;
  assign err       = r_head.err;

  // Next-state logic for the FIFO occupancy.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_EMPTY: if (w_push) w_next_state = ST_ONE;
      ST_ONE: begin
        if (w_push && !w_pop)      w_next_state = ST_FULL;
        else if (!w_push && w_pop) w_next_state = ST_EMPTY;
      end
      ST_FULL:  if (w_pop) w_next_state = ST_ONE;
      default:  w_next_state = ST_EMPTY;
    endcase
  end

  // State register; in_ready is precomputed from the next state so it never
  // depends combinationally on out_ready.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_EMPTY;
      r_in_ready <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_in_ready <= (w_next_state != ST_FULL);
    end
  end

  // Storage update: head always holds the oldest word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_head <= '0;
      r_tail <= '0;
    end else begin
      case (r_state)
        ST_EMPTY: if (w_push) r_head <= w_new;
        ST_ONE: begin
          if (w_push && w_pop) r_head <= w_new;
          else if (w_push)     r_tail <= w_new;
        end
        ST_FULL:  if (w_pop) r_head <= r_tail;
        default:  ;
      endcase
    end
  end

endmodule

// File: tb/tb_encode_imm_arith.sv
// Directed self-checking bench for encode_imm_arith.
import instr_type::*;

module tb_encode_imm_arith;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  imm_arith_kind_t kind;
  logic [4:0]      rd;
  logic [4:0]      rs1;
  logic [11:0]     imm;
  logic            out_valid;
  logic            out_ready;
  logic [31:0]     instr;
  logic            err;

  int tests = 0;
  int fails = 0;

  logic [31:0] stream_words [0:8];

  encode_imm_arith dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .kind      (kind),
    .rd        (rd),
    .rs1       (rs1),
    .imm       (imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .instr     (instr),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input imm_arith_kind_t k, input logic [4:0] d, input logic [4:0] s,
                       input logic [11:0] i);
    in_valid = 1'b1;
    kind     = k;
    rd       = d;
    rs1      = s;
    imm      = i;
  endtask

  initial begin
    stream_words[0] = 32'h00004013;
    stream_words[1] = 32'h00104093;
    stream_words[2] = 32'h00204113;
    stream_words[3] = 32'h00304193;
    stream_words[4] = 32'h00404213;
    stream_words[5] = 32'h00504293;
    stream_words[6] = 32'h00604313;
    stream_words[7] = 32'h00704393;
    stream_words[8] = 32'h00804413;

    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    kind = IAK_INVALID; rd = '0; rs1 = '0; imm = '0;

    // Reset state
    tick(); tick();
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_in_ready",  {31'd0, in_ready},  32'd0);
    check("rst_instr",     instr,              32'h0);
    check("rst_err",       {31'd0, err},       32'd0);
    rst = 1'b1;
    tick();
    check("release_in_ready", {31'd0, in_ready}, 32'd1);

    // addi x1, x0, 5 with one-cycle latency
    out_ready = 1'b1;
    drive(IAK_ADDI, 5'd1, 5'd0, 12'd5);
    tick();
    in_valid = 1'b0;
    check("addi_valid", {31'd0, out_valid}, 32'd1);
    check("addi_instr", instr,              32'h00500093);
    check("addi_err",   {31'd0, err},       32'd0);
    tick();
    check("addi_drained", {31'd0, out_valid}, 32'd0);

    // srai then andi via simultaneous push/pop in ONE
    drive(IAK_SRAI, 5'd2, 5'd3, 12'd7);
    tick();
    check("srai_instr", instr, 32'h4071D113);
    drive(IAK_ANDI, 5'd5, 5'd6, 12'hFFF);
    tick();
    in_valid = 1'b0;
    check("andi_valid", {31'd0, out_valid}, 32'd1);
    check("andi_instr", instr,              32'hFFF37293);
    check("andi_err",   {31'd0, err},       32'd0);
    tick();
    check("andi_drained", {31'd0, out_valid}, 32'd0);

    // Backpressure: three pushes with out_ready=0
    out_ready = 1'b0;
    drive(IAK_ADDI, 5'd1, 5'd0, 12'd1);
    tick();
    check("bp1_in_ready", {31'd0, in_ready}, 32'd1);
    drive(IAK_ADDI, 5'd2, 5'd0, 12'd2);
    tick();
    check("bp2_in_ready", {31'd0, in_ready}, 32'd0);
    check("bp2_head",     instr,             32'h00100093);
    drive(IAK_ADDI, 5'd3, 5'd0, 12'd3);
    tick();
    check("bp3_in_ready", {31'd0, in_ready}, 32'd0);
    check("bp3_head",     instr,             32'h00100093);
    tick();
    check("bp_hold_head", instr, 32'h00100093);
    out_ready = 1'b1;
    tick();
    check("bp_word2",     instr,             32'h00200113);
    check("bp_in_ready",  {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    check("bp_word3",     instr,              32'h00300193);
    check("bp_w3_valid",  {31'd0, out_valid}, 32'd1);
    tick();
    check("bp_drained",   {31'd0, out_valid}, 32'd0);

    // Invalid kinds and shamt handling
    drive(IAK_INVALID, 5'd7, 5'd8, 12'h123);
    tick();
    check("inv_instr", instr,        32'h0);
    check("inv_err",   {31'd0, err}, 32'd1);
    drive(imm_arith_kind_t'(4'd13), 5'd1, 5'd1, 12'h001);
    tick();
    check("unlisted_instr", instr,        32'h0);
    check("unlisted_err",   {31'd0, err}, 32'd1);
    drive(IAK_SLLI, 5'd0, 5'd0, 12'h021);
    tick();
    in_valid = 1'b0;
`ifdef ENCODE_IMM_ARITH_SHAMT_CHECK_EN
    check("slli_wide_instr", instr,        32'h0);
    check("slli_wide_err",   {31'd0, err}, 32'd1);
`else
    check("slli_wide_instr", instr,        32'h00101013);
    check("slli_wide_err",   {31'd0, err}, 32'd0);
`endif
    tick();
    check("inv_drained", {31'd0, out_valid}, 32'd0);

    // Reset while FULL
    out_ready = 1'b0;
    drive(IAK_ORI, 5'd4, 5'd4, 12'h044);
    tick();
    drive(IAK_XORI, 5'd9, 5'd9, 12'h099);
    tick();
    in_valid = 1'b0;
    check("full_in_ready", {31'd0, in_ready},  32'd0);
    check("full_valid",    {31'd0, out_valid}, 32'd1);
    rst = 1'b0;
    #1;
    check("midrst_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_ready", {31'd0, in_ready},  32'd0);
    check("midrst_instr", instr,              32'h0);
    tick();
    rst = 1'b1;
    out_ready = 1'b1;
    tick();
    check("postrst_ready", {31'd0, in_ready}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      check("postrst_no_word", {31'd0, out_valid}, 32'd0);
      tick();
    end

    // Continuous streaming in ONE
    drive(IAK_XORI, 5'd0, 5'd0, 12'd0);
    tick();
    check("stream_w0", instr, stream_words[0]);
    for (int i = 1; i <= 8; i++) begin
      drive(IAK_XORI, 5'(i), 5'd0, 12'(i));
      tick();
      check("stream_valid", {31'd0, out_valid}, 32'd1);
      check("stream_ready", {31'd0, in_ready},  32'd1);
      check("stream_word",  instr,              stream_words[i]);
    end
    in_valid = 1'b0;
    tick();
    check("stream_drained", {31'd0, out_valid}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
